fpu_dec: RTL and testbench

//   Operand decoder at the front of the single-precision FPU, and the counterpart of the result encoder.
//   It unpacks two IEEE-754 binary32 operands into sign, biased exponent and significand (hidden bit restored).
//   It classifies each operand and predicts the 5-bit output type consumed by the encoder:
//   [4]=NAN [3]=POS_inf [2]=NEG_inf [1]=INDET [0]=FINITE.
//   It also produces the quieted NaN payload (fpu_res_nan). Downstream arithmetic units start from its registered outputs.

---
 rtl/fpu_dec.sv | 178 +++++++++++++++++
 tb/tb_fpu_dec.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fpu_dec.sv
// Operand decoder for the single-precision FPU: unpacks and classifies both operands,
// predicts the encoder's output type and the quieted NaN result, all registered with one cycle latency.
module fpu_dec #(
    parameter int OPERAND_WIDTH     = 32,
    parameter int EXPONENT_WIDTH    = 8,
    parameter int FRACTION_WIDTH    = 23,
    parameter int SIGNIFICAND_WIDTH = FRACTION_WIDTH + 1
) (
    input  logic                         fpu_clk,
    input  logic                         fpu_rst_n,
    input  logic                         fpu_dec_en_i,
    input  logic [2:0]                   fpu_opcode_i,
    input  logic [OPERAND_WIDTH-1:0]     fpu_op_a_i,
    input  logic [OPERAND_WIDTH-1:0]     fpu_op_b_i,
    output logic                         fpu_dec_ready_o,
    output logic                         fpu_a_sign_o,
    output logic [EXPONENT_WIDTH-1:0]    fpu_a_exp_o,
    output logic [SIGNIFICAND_WIDTH-1:0] fpu_a_sig_o,
    output logic [5:0]                   fpu_a_class_o,
    output logic                         fpu_b_sign_o,
    output logic [EXPONENT_WIDTH-1:0]    fpu_b_exp_o,
    output logic [SIGNIFICAND_WIDTH-1:0] fpu_b_sig_o,
    output logic [5:0]                   fpu_b_class_o,
    output logic [4:0]                   fpu_out_type_o,
    output logic [OPERAND_WIDTH-1:0]     fpu_res_nan_o,
    output logic                         fpu_dec_invalid_o
);

    // state  | meaning
    // IDLE   | no operation active, all outputs held at 0
    // DECODE | outputs carry the operands sampled on the previous edge
    typedef enum logic {IDLE, DECODE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    state_t state, state_nxt;

    function automatic logic [5:0] classify(input logic [OPERAND_WIDTH-1:0] op);
        logic [EXPONENT_WIDTH-1:0] e;
        logic [FRACTION_WIDTH-1:0] f;
        e = op[OPERAND_WIDTH-2 -: EXPONENT_WIDTH];
        f = op[FRACTION_WIDTH-1:0];
        if (&e) begin
            if (f == '0)                     classify = 6'b001000;
            else if (f[FRACTION_WIDTH-1])    classify = 6'b010000;
            else                             classify = 6'b100000;
        end else if (e == '0) begin
            classify = (f == '0) ? 6'b000100 : 6'b000010;
        end else begin
            classify = 6'b000001;
        end
    endfunction

    logic [5:0]                   a_cls, b_cls;
    logic [EXPONENT_WIDTH-1:0]    a_e, b_e, a_exp_d, b_exp_d;
    logic [SIGNIFICAND_WIDTH-1:0] a_sig_d, b_sig_d;
    logic                         a_s, b_s, unary;
    logic                         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_fin_nz;
    logic                         indet, inf_res, inf_sign;
    logic [4:0]                   out_type_d;
    logic [OPERAND_WIDTH-1:0]     res_nan_d, nan_src;
    logic                         invalid_d;

    always_comb begin
        a_cls    = classify(fpu_op_a_i);
        b_cls    = classify(fpu_op_b_i);
        a_s      = fpu_op_a_i[OPERAND_WIDTH-1];
        b_s      = fpu_op_b_i[OPERAND_WIDTH-1];
        a_e      = fpu_op_a_i[OPERAND_WIDTH-2 -: EXPONENT_WIDTH];
        b_e      = fpu_op_b_i[OPERAND_WIDTH-2 -: EXPONENT_WIDTH];
        a_exp_d  = a_cls[1] ? EXPONENT_WIDTH'(1) : a_e;
        b_exp_d  = b_cls[1] ? EXPONENT_WIDTH'(1) : b_e;
        a_sig_d  = {(a_e != '0), fpu_op_a_i[FRACTION_WIDTH-1:0]};
        b_sig_d  = {(b_e != '0), fpu_op_b_i[FRACTION_WIDTH-1:0]};
        unary    = fpu_opcode_i[2];
        a_nan    = a_cls[5] | a_cls[4];
        b_nan    = ~unary & (b_cls[5] | b_cls[4]);
        a_inf    = a_cls[3];
        b_inf    = b_cls[3];
        a_zero   = a_cls[2];
        b_zero   = b_cls[2];
        a_fin_nz = a_cls[1] | a_cls[0];

        indet    = 1'b0;
        inf_res  = 1'b0;
        inf_sign = 1'b0;
        case (fpu_opcode_i)
            OP_ADD: begin
                indet    = a_inf & b_inf & (a_s != b_s);
                inf_res  = a_inf | b_inf;
                inf_sign = a_inf ? a_s : b_s;
            end
            OP_SUB: begin
                indet    = a_inf & b_inf & (a_s == b_s);
                inf_res  = a_inf | b_inf;
                inf_sign = a_inf ? a_s : ~b_s;
            end
            OP_MUL: begin
                indet    = (a_zero & b_inf) | (a_inf & b_zero);
                inf_res  = a_inf | b_inf;
                inf_sign = a_s ^ b_s;
            end
            OP_DIV: begin
                indet    = (a_zero & b_zero) | (a_inf & b_inf);
                inf_res  = a_inf | (a_fin_nz & b_zero);
                inf_sign = a_s ^ b_s;
            end
            default: begin
                inf_res  = a_inf;
                inf_sign = a_s;
            end
        endcase

        if (a_nan | b_nan)   out_type_d = 5'b10000;
        else if (indet)      out_type_d = 5'b00010;
        else if (inf_res)    out_type_d = inf_sign ? 5'b00100 : 5'b01000;
        else                 out_type_d = 5'b00001;

        // A takes precedence as the NaN source; the quiet bit is forced, sign and payload kept
        nan_src   = a_nan ? fpu_op_a_i : fpu_op_b_i;
        res_nan_d = '0;
        if (a_nan | b_nan) begin
            res_nan_d = nan_src;
            res_nan_d[FRACTION_WIDTH-1] = 1'b1;
        end

        invalid_d = indet | a_cls[5] | (~unary & b_cls[5]);
    end

    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fpu_dec_en_i)  state_nxt = DECODE;
            DECODE:  if (!fpu_dec_en_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fpu_dec_ready_o = (state == DECODE);

    // Data outputs are zeroed whenever enable drops so downstream OR-muxes see 0 when not ready
    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n || !fpu_dec_en_i) begin
            fpu_a_sign_o      <= 1'b0;
            fpu_a_exp_o       <= '0;
            fpu_a_sig_o       <= '0;
            fpu_a_class_o     <= '0;
            fpu_b_sign_o      <= 1'b0;
            fpu_b_exp_o       <= '0;
            fpu_b_sig_o       <= '0;
            fpu_b_class_o     <= '0;
            fpu_out_type_o    <= '0;
            fpu_res_nan_o     <= '0;
            fpu_dec_invalid_o <= 1'b0;
        end else begin
            fpu_a_sign_o      <= a_s;
            fpu_a_exp_o       <= a_exp_d;
            fpu_a_sig_o       <= a_sig_d;
            fpu_a_class_o     <= a_cls;
            fpu_b_sign_o      <= b_s;
            fpu_b_exp_o       <= b_exp_d;
            fpu_b_sig_o       <= b_sig_d;
            fpu_b_class_o     <= b_cls;
            fpu_out_type_o    <= out_type_d;
            fpu_res_nan_o     <= res_nan_d;
            fpu_dec_invalid_o <= invalid_d;
        end
    end

endmodule

// File: tb/tb_fpu_dec.sv
// Directed bench for fpu_dec: hand-computed vectors checked with immediate assertions.
module tb_fpu_dec;

    logic        fpu_clk = 1'b0;
    logic        fpu_rst_n;
    logic        en;
    logic [2:0]  opcode;
    logic [31:0] op_a, op_b;
    logic        ready, a_sign, b_sign, invalid;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_sig, b_sig;
    logic [5:0]  a_class, b_class;
    logic [4:0]  out_type;
    logic [31:0] res_nan;

    int n_checks = 0;
    int n_errors = 0;

    fpu_dec dut (
        .fpu_clk           (fpu_clk),
        .fpu_rst_n         (fpu_rst_n),
        .fpu_dec_en_i      (en),
        .fpu_opcode_i      (opcode),
        .fpu_op_a_i        (op_a),
        .fpu_op_b_i        (op_b),
        .fpu_dec_ready_o   (ready),
        .fpu_a_sign_o      (a_sign),
        .fpu_a_exp_o       (a_exp),
        .fpu_a_sig_o       (a_sig),
        .fpu_a_class_o     (a_class),
        .fpu_b_sign_o      (b_sign),
        .fpu_b_exp_o       (b_exp),
        .fpu_b_sig_o       (b_sig),
        .fpu_b_class_o     (b_class),
        .fpu_out_type_o    (out_type),
        .fpu_res_nan_o     (res_nan),
        .fpu_dec_invalid_o (invalid)
    );

    always #5 fpu_clk = ~fpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge fpu_clk);
        #1;
    endtask

    task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        en = 1'b1; opcode = op; op_a = a; op_b = b;
    endtask

    initial begin
        fpu_rst_n = 1'b0;
        apply(3'b000, 32'h3F800000, 32'h0);
        step(); step();
        check("rst_ready",    32'(ready),    32'h0);
        check("rst_a_exp",    32'(a_exp),    32'h0);
        check("rst_a_sig",    32'(a_sig),    32'h0);
        check("rst_out_type", 32'(out_type), 32'h0);
        check("rst_a_class",  32'(a_class),  32'h0);

        fpu_rst_n = 1'b1;
        step();
        check("one_ready",    32'(ready),    32'h1);
        check("one_a_exp",    32'(a_exp),    32'h7F);
        check("one_a_sig",    32'(a_sig),    32'h800000);
        check("one_out_type", 32'(out_type), 32'h01);
        check("one_a_class",  32'(a_class),  32'h01);

        apply(3'b000, 32'h7F800000, 32'hFF800000);
        step();
        check("add_indet_type", 32'(out_type), 32'h02);
        check("add_indet_inv",  32'(invalid),  32'h1);

        apply(3'b001, 32'h7F800000, 32'hFF800000);
        step();
        check("sub_inf_type", 32'(out_type), 32'h08);
        check("sub_inf_inv",  32'(invalid),  32'h0);

        apply(3'b010, 32'h7F800001, 32'h7FC12345);
        step();
        check("mul_nan_type",    32'(out_type), 32'h10);
        check("mul_nan_res",     res_nan,       32'h7FC00001);
        check("mul_nan_inv",     32'(invalid),  32'h1);
        check("mul_nan_a_class", 32'(a_class),  32'h20);
        check("mul_nan_b_class", 32'(b_class),  32'h10);

        apply(3'b011, 32'h40000000, 32'h80000000);
        step();
        check("div_by0_type",    32'(out_type), 32'h04);
        check("div_by0_inv",     32'(invalid),  32'h0);
        check("div_by0_b_class", 32'(b_class),  32'h04);
        check("div_by0_b_sign",  32'(b_sign),   32'h1);

        apply(3'b011, 32'h00000000, 32'h00000000);
        step();
        check("div_00_type", 32'(out_type), 32'h02);
        check("div_00_inv",  32'(invalid),  32'h1);

        apply(3'b100, 32'h00000001, 32'h7F800000);
        step();
        check("un_sub_class", 32'(a_class),  32'h02);
        check("un_sub_exp",   32'(a_exp),    32'h01);
        check("un_sub_sig",   32'(a_sig),    32'h000001);
        check("un_sub_type",  32'(out_type), 32'h01);
        check("un_sub_inv",   32'(invalid),  32'h0);

        apply(3'b000, 32'h3F800000, 32'hFF800000);
        step();
        check("add_neginf_type", 32'(out_type), 32'h04);

        apply(3'b011, 32'h3F800000, 32'h7F800000);
        step();
        check("div_fin_inf_type", 32'(out_type), 32'h01);

        apply(3'b111, 32'hFF800000, 32'h7F800001);
        step();
        check("un7_neginf_type", 32'(out_type), 32'h04);
        check("un7_inv",         32'(invalid),  32'h0);

        apply(3'b001, 32'h7F800000, 32'h7F800000);
        step();
        check("sub_indet_type", 32'(out_type), 32'h02);

        apply(3'b000, 32'h3F800000, 32'h0);
        step();
        check("s1_a_exp",  32'(a_exp),  32'h7F);
        apply(3'b000, 32'h40000000, 32'h0);
        step();
        check("s2_a_exp",  32'(a_exp),  32'h80);
        check("s2_ready",  32'(ready),  32'h1);
        apply(3'b000, 32'hC0400000, 32'h0);
        step();
        check("s3_a_sign", 32'(a_sign), 32'h1);
        check("s3_a_sig",  32'(a_sig),  32'hC00000);
        en = 1'b0;
        step();
        check("off_ready",    32'(ready),    32'h0);
        check("off_a_exp",    32'(a_exp),    32'h0);
        check("off_a_sig",    32'(a_sig),    32'h0);
        check("off_a_sign",   32'(a_sign),   32'h0);
        check("off_out_type", 32'(out_type), 32'h0);

        apply(3'b000, 32'h7FC00000, 32'h3F800000);
        step();
        check("q_ready",   32'(ready),    32'h1);
        check("q_type",    32'(out_type), 32'h10);
        check("q_res_nan", res_nan,       32'h7FC00000);
        #2 fpu_rst_n = 1'b0;
        #1;
        check("arst_ready",   32'(ready),    32'h0);
        check("arst_type",    32'(out_type), 32'h0);
        check("arst_res_nan", res_nan,       32'h0);
        check("arst_a_exp",   32'(a_exp),    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
